// File: rtl/bingo_game_ctrl_if.sv
// Interboard link between the Bingo turn controller and the link transmitter/receiver.
// The master side drives outgoing messages and consumes peer messages.
interface bingo_game_ctrl_if #(
  parameter int unsigned NUM_W = 5
);
  // Outgoing message, held stable while tx_valid until tx_ready.
  logic             tx_valid;
  logic [2:0]       tx_type;
  logic [NUM_W-1:0] tx_number;
  logic             tx_ready;
  // Incoming peer message, valid for the single cycle rx_en is high.
  logic             rx_en;
  logic [2:0]       rx_type;
  logic [NUM_W-1:0] rx_number;

  modport master (
    output tx_valid,
    output tx_type,
    output tx_number,
    input  tx_ready,
    input  rx_en,
    input  rx_type,
    input  rx_number
  );

  modport slave (
    input  tx_valid,
    input  tx_type,
    input  tx_number,
    output tx_ready,
    output rx_en,
    output rx_type,
    output rx_number
  );
endinterface

// File: rtl/bingo_game_ctrl.sv
// Master-side Bingo turn controller for an NxN board: start/selection handshakes, alternating
// guesses with the peer, circle/used bitmaps, line counting against a win threshold and
// auto-pick of the lowest unused number when the local turn times out.
module bingo_game_ctrl #(
  parameter int unsigned N            = 5,
  parameter int unsigned WIN_LINES    = 1,
  parameter int unsigned TURN_TIMEOUT = 0,
  localparam int unsigned CELLS  = N * N,
  localparam int unsigned NUM_W  = $clog2(CELLS + 1),
  localparam int unsigned POS_W  = NUM_W,
  localparam int unsigned LINE_W = $clog2(2 * N + 3)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_game,
  input  logic                   sel_done,
  input  logic [CELLS*POS_W-1:0] num_to_pos,
  input  logic                   pick_valid,
  input  logic [NUM_W-1:0]       pick_number,
  bingo_game_ctrl_if.master      link,
  output logic [3:0]             state,
  output logic [CELLS-1:0]       circle,
  output logic [CELLS-1:0]       used,
  output logic [LINE_W-1:0]      lines_done,
  output logic                   pick_reject,
  output logic [1:0]             result
);

  typedef enum logic [3:0] {
    StIdle          = 4'd0,
    StSendStart     = 4'd1,
    StLocalSel      = 4'd2,
    StSendSelDone   = 4'd3,
    StWaitPeerSel   = 4'd4,
    StLocalGuess    = 4'd5,
    StSendGuess     = 4'd6,
    StCheck         = 4'd7,
    StSendWin       = 4'd8,
    StWaitPeerGuess = 4'd9,
    StFin           = 4'd10
  } state_e;

  localparam logic [2:0] MsgTurn   = 3'd1;
  localparam logic [2:0] MsgSelNum = 3'd2;
  localparam logic [2:0] MsgWin    = 3'd3;

  localparam bit              TO_EN   = (TURN_TIMEOUT != 0);
  localparam int unsigned     TO_W    = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);
  localparam logic [LINE_W-1:0] WIN_TH = LINE_W'(WIN_LINES);

  state_e             state_q, state_d;
  logic [CELLS-1:0]   circle_q, circle_d;
  logic [CELLS-1:0]   used_q, used_d;
  logic [1:0]         result_q, result_d;
  logic [NUM_W-1:0]   move_num_q, move_num_d;
  logic               last_local_q, last_local_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic               pick_reject_q, pick_reject_d;
  logic               tx_valid_q, tx_valid_d;
  logic [2:0]         tx_type_q, tx_type_d;
  logic [NUM_W-1:0]   tx_number_q, tx_number_d;

  logic               pick_ok, rx_ok, auto_any, take;
  logic [NUM_W-1:0]   auto_num, take_num;
  logic [LINE_W-1:0]  line_cnt;
  logic               row_all, col_all, diag_a, diag_b;

  // True when num is in 1..CELLS and has not been called yet.
  function automatic logic num_free(input logic [NUM_W-1:0] num, input logic [CELLS-1:0] used_v);
    logic ok;
    ok = 1'b0;
    for (int unsigned k = 1; k <= CELLS; k++) begin
      if (num == NUM_W'(k) && !used_v[k-1]) ok = 1'b1;
    end
    return ok;
  endfunction

  // One-hot used bit for number num (bit num-1); zero when out of range.
  function automatic logic [CELLS-1:0] num_mask(input logic [NUM_W-1:0] num);
    logic [CELLS-1:0] m;
    m = '0;
    for (int unsigned k = 1; k <= CELLS; k++) begin
      if (num == NUM_W'(k)) m[k-1] = 1'b1;
    end
    return m;
  endfunction

  // One-hot board position of number num via the placement map; zero if unmapped.
  function automatic logic [CELLS-1:0] pos_mask(input logic [NUM_W-1:0] num,
                                                input logic [CELLS*POS_W-1:0] map);
    logic [CELLS-1:0] m;
    logic [POS_W-1:0] pos;
    m = '0;
    for (int unsigned k = 1; k <= CELLS; k++) begin
      if (num == NUM_W'(k)) begin
        pos = map[(k-1)*POS_W +: POS_W];
        for (int unsigned c = 0; c < CELLS; c++) begin
          if (pos == POS_W'(c)) m[c] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  // Count complete rows, columns and both diagonals of the circle bitmap.
  always_comb begin
    line_cnt = '0;
    row_all  = 1'b1;
    col_all  = 1'b1;
    diag_a   = 1'b1;
    diag_b   = 1'b1;
    for (int unsigned r = 0; r < N; r++) begin
      row_all = 1'b1;
      col_all = 1'b1;
      for (int unsigned c = 0; c < N; c++) begin
        row_all = row_all & circle_q[r*N + c];
        col_all = col_all & circle_q[c*N + r];
      end
      if (row_all) line_cnt = line_cnt + 1'b1;
      if (col_all) line_cnt = line_cnt + 1'b1;
      diag_a = diag_a & circle_q[r*N + r];
      diag_b = diag_b & circle_q[r*N + (N - 1 - r)];
    end
    if (diag_a) line_cnt = line_cnt + 1'b1;
    if (diag_b) line_cnt = line_cnt + 1'b1;
  end

  // Lowest unused number, used when the local turn times out.
  always_comb begin
    auto_any = 1'b0;
    auto_num = '0;
    for (int unsigned k = CELLS; k >= 1; k--) begin
      if (!used_q[k-1]) begin
        auto_any = 1'b1;
        auto_num = NUM_W'(k);
      end
    end
  end

  // Move qualification for local pick, timeout auto-pick and peer SEL_NUM.
  always_comb begin
    pick_ok  = num_free(pick_number, used_q);
    rx_ok    = num_free(link.rx_number, used_q);
    take     = 1'b0;
    take_num = pick_number;
    if (pick_valid && pick_ok) begin
      take = 1'b1;
    end else if (TO_EN && cnt_q == TO_LAST && auto_any) begin
      // A valid manual pick wins over a same-cycle timeout.
      take     = 1'b1;
      take_num = auto_num;
    end
  end

  // Next-state, bitmap, result and registered link outputs.
  always_comb begin
    state_d       = state_q;
    circle_d      = circle_q;
    used_d        = used_q;
    result_d      = result_q;
    move_num_d    = move_num_q;
    last_local_d  = last_local_q;
    cnt_d         = '0;
    pick_reject_d = 1'b0;

    case (state_q)
      StIdle:        if (start_game) state_d = StSendStart;
      StSendStart:   if (link.tx_ready) state_d = StLocalSel;
      StLocalSel:    if (sel_done) state_d = StSendSelDone;
      StSendSelDone: if (link.tx_ready) state_d = StWaitPeerSel;
      StWaitPeerSel: if (link.rx_en && link.rx_type == MsgTurn) state_d = StLocalGuess;
      StLocalGuess: begin
        if (pick_valid && !pick_ok) pick_reject_d = 1'b1;
        if (take) begin
          circle_d     = circle_q | pos_mask(take_num, num_to_pos);
          used_d       = used_q | num_mask(take_num);
          move_num_d   = take_num;
          last_local_d = 1'b1;
          state_d      = StSendGuess;
        end else if (TO_EN && cnt_q != TO_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      StSendGuess:   if (link.tx_ready) state_d = StCheck;
      StCheck: begin
        if (line_cnt >= WIN_TH)  state_d = StSendWin;
        else if (last_local_q)   state_d = StWaitPeerGuess;
        else                     state_d = StLocalGuess;
      end
      StSendWin: begin
        if (link.tx_ready) begin
          state_d  = StFin;
          result_d = 2'd1;
        end
      end
      StWaitPeerGuess: begin
        if (link.rx_en) begin
          if (link.rx_type == MsgWin) begin
            state_d  = StFin;
            result_d = 2'd2;
          end else if (link.rx_type == MsgSelNum && rx_ok) begin
            circle_d     = circle_q | pos_mask(link.rx_number, num_to_pos);
            used_d       = used_q | num_mask(link.rx_number);
            last_local_d = 1'b0;
            state_d      = StCheck;
          end
        end
      end
      StFin: begin
        if (start_game) begin
          state_d  = StIdle;
          circle_d = '0;
          used_d   = '0;
          result_d = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Link outputs follow the next state so they line up with state_q.
    tx_valid_d  = 1'b0;
    tx_type_d   = 3'd0;
    tx_number_d = '0;
    case (state_d)
      StSendStart, StSendSelDone: begin
        tx_valid_d = 1'b1;
        tx_type_d  = MsgTurn;
      end
      StSendGuess: begin
        tx_valid_d  = 1'b1;
        tx_type_d   = MsgSelNum;
        tx_number_d = move_num_d;
      end
      StSendWin: begin
        tx_valid_d = 1'b1;
        tx_type_d  = MsgWin;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      circle_q      <= '0;
      used_q        <= '0;
      result_q      <= 2'd0;
      move_num_q    <= '0;
      last_local_q  <= 1'b0;
      cnt_q         <= '0;
      pick_reject_q <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_type_q     <= 3'd0;
      tx_number_q   <= '0;
    end else begin
      state_q       <= state_d;
      circle_q      <= circle_d;
      used_q        <= used_d;
      result_q      <= result_d;
      move_num_q    <= move_num_d;
      last_local_q  <= last_local_d;
      cnt_q         <= cnt_d;
      pick_reject_q <= pick_reject_d;
      tx_valid_q    <= tx_valid_d;
      tx_type_q     <= tx_type_d;
      tx_number_q   <= tx_number_d;
    end
  end

  assign state          = state_q;
  assign circle         = circle_q;
  assign used           = used_q;
  assign lines_done     = line_cnt;
  assign pick_reject    = pick_reject_q;
  assign result         = result_q;
  assign link.tx_valid  = tx_valid_q;
  assign link.tx_type   = tx_type_q;
  assign link.tx_number = tx_number_q;

endmodule

// File: tb/tb_bingo_game_ctrl.sv
// Directed bench: dut_a (WIN_LINES=1, no timeout) and dut_b (WIN_LINES=3, TURN_TIMEOUT=8)
// share all inputs; each scenario checks whichever instance it targets.
module tb_bingo_game_ctrl;
  localparam int unsigned CELLS = 25;
  localparam int unsigned NUM_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_game = 1'b0, sel_done = 1'b0, pick_valid = 1'b0, rx_en = 1'b0, tx_ready = 1'b1;
  logic [NUM_W-1:0] pick_number = '0, rx_number = '0;
  logic [2:0] rx_type = 3'd0;
  logic [CELLS*NUM_W-1:0] num_to_pos;

  logic [3:0] st_a, st_b;
  logic [CELLS-1:0] circle_a, circle_b, used_a, used_b;
  logic [3:0] lines_a, lines_b;
  logic rej_a, rej_b;
  logic [1:0] res_a, res_b;

  int checks = 0;
  int errors = 0;

  bingo_game_ctrl_if #(.NUM_W(NUM_W)) link_a ();
  bingo_game_ctrl_if #(.NUM_W(NUM_W)) link_b ();
  assign link_a.tx_ready = tx_ready;
  assign link_a.rx_en = rx_en;
  assign link_a.rx_type = rx_type;
  assign link_a.rx_number = rx_number;
  assign link_b.tx_ready = tx_ready;
  assign link_b.rx_en = rx_en;
  assign link_b.rx_type = rx_type;
  assign link_b.rx_number = rx_number;

  bingo_game_ctrl #(.N(5), .WIN_LINES(1), .TURN_TIMEOUT(0)) dut_a (
    .clk(clk), .rst(rst), .start_game(start_game), .sel_done(sel_done),
    .num_to_pos(num_to_pos), .pick_valid(pick_valid), .pick_number(pick_number),
    .link(link_a), .state(st_a), .circle(circle_a), .used(used_a), .lines_done(lines_a),
    .pick_reject(rej_a), .result(res_a)
  );

  bingo_game_ctrl #(.N(5), .WIN_LINES(3), .TURN_TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .start_game(start_game), .sel_done(sel_done),
    .num_to_pos(num_to_pos), .pick_valid(pick_valid), .pick_number(pick_number),
    .link(link_b), .state(st_b), .circle(circle_b), .used(used_b), .lines_done(lines_b),
    .pick_reject(rej_b), .result(res_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_game = 1'b0; sel_done = 1'b0; pick_valid = 1'b0; rx_en = 1'b0; tx_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Start through selection to LOCAL_GUESS in 5 cycles with tx_ready held high.
  task automatic go_guess();
    start_game = 1'b1; tick(); start_game = 1'b0;
    tick();
    sel_done = 1'b1; tick(); sel_done = 1'b0;
    tick();
    rx_en = 1'b1; rx_type = 3'd1; tick(); rx_en = 1'b0;
  endtask

  task automatic local_pick(input logic [NUM_W-1:0] n);
    pick_valid = 1'b1; pick_number = n; tick(); pick_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic peer_num(input logic [NUM_W-1:0] n);
    rx_en = 1'b1; rx_type = 3'd2; rx_number = n; tick(); rx_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (st_a !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", st_a); end
    checks++; if (link_a.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_txv got %0b want 0", link_a.tx_valid); end
    checks++; if (circle_a !== '0 || used_a !== '0) begin errors++; $display("FAIL rst_maps got %h/%h want 0/0", circle_a, used_a); end
    checks++; if (res_a !== 2'd0 || rej_a !== 1'b0) begin errors++; $display("FAIL rst_res_rej got %0d/%0b want 0/0", res_a, rej_a); end
    checks++; if (lines_a !== 4'd0) begin errors++; $display("FAIL rst_lines got %0d want 0", lines_a); end
  endtask

  task automatic test_handshake();
    do_reset();
    tx_ready = 1'b0;
    start_game = 1'b1; tick(); start_game = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (st_a !== 4'd1 || link_a.tx_valid !== 1'b1 || link_a.tx_type !== 3'd1 || link_a.tx_number !== 5'd0) begin
        errors++;
        $display("FAIL hs_hold%0d got st=%0d v=%0b t=%0d n=%0d want 1/1/1/0", i, st_a,
                 link_a.tx_valid, link_a.tx_type, link_a.tx_number);
      end
      tick();
    end
    tx_ready = 1'b1; tick();
    checks++; if (st_a !== 4'd2 || link_a.tx_valid !== 1'b0) begin errors++; $display("FAIL hs_accept got st=%0d v=%0b want 2/0", st_a, link_a.tx_valid); end
    rx_en = 1'b1; rx_type = 3'd1; tick(); rx_en = 1'b0;
    checks++; if (st_a !== 4'd2) begin errors++; $display("FAIL hs_rx_ignored got %0d want 2", st_a); end
    sel_done = 1'b1; tick(); sel_done = 1'b0;
    checks++; if (st_a !== 4'd3 || link_a.tx_type !== 3'd1) begin errors++; $display("FAIL hs_seldone got st=%0d t=%0d want 3/1", st_a, link_a.tx_type); end
    tick();
    checks++; if (st_a !== 4'd4) begin errors++; $display("FAIL hs_waitsel got %0d want 4", st_a); end
    rx_en = 1'b1; rx_type = 3'd2; rx_number = 5'd3; tick(); rx_en = 1'b0;
    checks++; if (st_a !== 4'd4) begin errors++; $display("FAIL hs_selnum_ignored got %0d want 4", st_a); end
    rx_en = 1'b1; rx_type = 3'd1; tick(); rx_en = 1'b0;
    checks++; if (st_a !== 4'd5) begin errors++; $display("FAIL hs_to_guess got %0d want 5", st_a); end
  endtask

  task automatic test_local_win();
    do_reset();
    go_guess();
    pick_valid = 1'b1; pick_number = 5'd1; tick(); pick_valid = 1'b0;
    checks++; if (st_a !== 4'd6 || link_a.tx_type !== 3'd2 || link_a.tx_number !== 5'd1) begin errors++; $display("FAIL win_tx1 got st=%0d t=%0d n=%0d want 6/2/1", st_a, link_a.tx_type, link_a.tx_number); end
    tick(); tick();
    checks++; if (st_a !== 4'd9) begin errors++; $display("FAIL win_wait got %0d want 9", st_a); end
    peer_num(5'd6);
    checks++; if (st_a !== 4'd5 || used_a !== 25'h21) begin errors++; $display("FAIL win_peer6 got st=%0d used=%h want 5/21", st_a, used_a); end
    local_pick(5'd2); peer_num(5'd7);
    local_pick(5'd3); peer_num(5'd8);
    local_pick(5'd4); peer_num(5'd9);
    checks++; if (lines_a !== 4'd0) begin errors++; $display("FAIL win_lines0 got %0d want 0", lines_a); end
    pick_valid = 1'b1; pick_number = 5'd5; tick(); pick_valid = 1'b0;
    checks++; if (link_a.tx_number !== 5'd5) begin errors++; $display("FAIL win_tx5 got %0d want 5", link_a.tx_number); end
    tick();
    checks++; if (st_a !== 4'd7 || lines_a !== 4'd1) begin errors++; $display("FAIL win_check got st=%0d l=%0d want 7/1", st_a, lines_a); end
    tick();
    checks++; if (st_a !== 4'd8 || link_a.tx_valid !== 1'b1 || link_a.tx_type !== 3'd3) begin errors++; $display("FAIL win_sendwin got st=%0d v=%0b t=%0d want 8/1/3", st_a, link_a.tx_valid, link_a.tx_type); end
    tick();
    checks++; if (st_a !== 4'd10 || res_a !== 2'd1 || link_a.tx_valid !== 1'b0) begin errors++; $display("FAIL win_fin got st=%0d r=%0d v=%0b want 10/1/0", st_a, res_a, link_a.tx_valid); end
    checks++; if (circle_a !== 25'h1FF || used_a !== 25'h1FF) begin errors++; $display("FAIL win_maps got %h/%h want 1ff/1ff", circle_a, used_a); end
  endtask

  task automatic test_reject();
    logic [NUM_W-1:0] bad [3];
    bad[0] = 5'd7; bad[1] = 5'd0; bad[2] = 5'd26;
    do_reset();
    go_guess();
    local_pick(5'd1);
    peer_num(5'd7);
    for (int i = 0; i < 3; i++) begin
      pick_valid = 1'b1; pick_number = bad[i]; tick();
      checks++; if (rej_a !== 1'b1 || st_a !== 4'd5) begin errors++; $display("FAIL rej_%0d got rej=%0b st=%0d want 1/5", bad[i], rej_a, st_a); end
    end
    pick_valid = 1'b0; tick();
    checks++; if (rej_a !== 1'b0 || st_a !== 4'd5 || used_a !== 25'h41) begin errors++; $display("FAIL rej_after got rej=%0b st=%0d used=%h want 0/5/41", rej_a, st_a, used_a); end
  endtask

  task automatic test_timeout();
    do_reset();
    go_guess();
    local_pick(5'd1);
    peer_num(5'd2);
    for (int i = 0; i < 7; i++) tick();
    checks++; if (st_b !== 4'd5) begin errors++; $display("FAIL to_before got %0d want 5", st_b); end
    tick();
    checks++; if (st_b !== 4'd6 || link_b.tx_type !== 3'd2 || link_b.tx_number !== 5'd3) begin errors++; $display("FAIL to_auto got st=%0d t=%0d n=%0d want 6/2/3", st_b, link_b.tx_type, link_b.tx_number); end
    checks++; if (used_b !== 25'h7 || circle_b !== 25'h7) begin errors++; $display("FAIL to_maps got %h/%h want 7/7", used_b, circle_b); end
    checks++; if (st_a !== 4'd5) begin errors++; $display("FAIL to_disabled got %0d want 5", st_a); end
  endtask

  task automatic test_peer_win();
    do_reset();
    go_guess();
    local_pick(5'd1);
    pick_valid = 1'b1; pick_number = 5'd3; tick(); pick_valid = 1'b0;
    checks++; if (rej_a !== 1'b0 || used_a !== 25'h1 || st_a !== 4'd9) begin errors++; $display("FAIL pw_pick_ignored got rej=%0b used=%h st=%0d want 0/1/9", rej_a, used_a, st_a); end
    rx_en = 1'b1; rx_type = 3'd3; tick(); rx_en = 1'b0;
    checks++; if (st_a !== 4'd10 || res_a !== 2'd2 || link_a.tx_valid !== 1'b0) begin errors++; $display("FAIL pw_fin got st=%0d r=%0d v=%0b want 10/2/0", st_a, res_a, link_a.tx_valid); end
    tick();
    checks++; if (link_a.tx_valid !== 1'b0) begin errors++; $display("FAIL pw_notx got %0b want 0", link_a.tx_valid); end
    start_game = 1'b1; tick(); start_game = 1'b0;
    checks++; if (st_a !== 4'd0 || circle_a !== '0 || used_a !== '0 || res_a !== 2'd0) begin errors++; $display("FAIL pw_idle got st=%0d c=%h u=%h r=%0d want 0/0/0/0", st_a, circle_a, used_a, res_a); end
  endtask

  task automatic test_win_three();
    do_reset();
    go_guess();
    local_pick(5'd1);  peer_num(5'd6);
    local_pick(5'd2);  peer_num(5'd11);
    local_pick(5'd3);  peer_num(5'd16);
    local_pick(5'd4);  peer_num(5'd21);
    local_pick(5'd5);
    checks++; if (st_b !== 4'd9 || lines_b !== 4'd2) begin errors++; $display("FAIL w3_two got st=%0d l=%0d want 9/2", st_b, lines_b); end
    peer_num(5'd7);  local_pick(5'd8);
    peer_num(5'd9);  local_pick(5'd12);
    checks++; if (st_b !== 4'd9 || lines_b !== 4'd2) begin errors++; $display("FAIL w3_pre got st=%0d l=%0d want 9/2", st_b, lines_b); end
    rx_en = 1'b1; rx_type = 3'd2; rx_number = 5'd10; tick(); rx_en = 1'b0;
    checks++; if (st_b !== 4'd7 || lines_b !== 4'd3) begin errors++; $display("FAIL w3_check got st=%0d l=%0d want 7/3", st_b, lines_b); end
    tick();
    checks++; if (st_b !== 4'd8 || link_b.tx_type !== 3'd3) begin errors++; $display("FAIL w3_sendwin got st=%0d t=%0d want 8/3", st_b, link_b.tx_type); end
    tick();
    checks++; if (st_b !== 4'd10 || res_b !== 2'd1) begin errors++; $display("FAIL w3_fin got st=%0d r=%0d want 10/1", st_b, res_b); end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    go_guess();
    tx_ready = 1'b0;
    pick_valid = 1'b1; pick_number = 5'd4; tick(); pick_valid = 1'b0;
    tick();
    checks++; if (st_b !== 4'd6 || link_b.tx_valid !== 1'b1) begin errors++; $display("FAIL rm_hold got st=%0d v=%0b want 6/1", st_b, link_b.tx_valid); end
    rst = 1'b1; tick(); rst = 1'b0; tx_ready = 1'b1;
    checks++; if (st_b !== 4'd0 || link_b.tx_valid !== 1'b0 || link_b.tx_type !== 3'd0 || link_b.tx_number !== 5'd0) begin errors++; $display("FAIL rm_tx got st=%0d v=%0b t=%0d n=%0d want 0/0/0/0", st_b, link_b.tx_valid, link_b.tx_type, link_b.tx_number); end
    checks++; if (circle_b !== '0 || used_b !== '0 || res_b !== 2'd0) begin errors++; $display("FAIL rm_maps got c=%h u=%h r=%0d want 0/0/0", circle_b, used_b, res_b); end
  endtask

  initial begin
    // Identity placement: number k sits at position k-1.
    for (int k = 1; k <= CELLS; k++) num_to_pos[(k-1)*NUM_W +: NUM_W] = NUM_W'(k - 1);
    test_reset();
    test_handshake();
    test_local_win();
    test_reject();
    test_timeout();
    test_peer_win();
    test_win_three();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
